// File: rtl/mem_arb_2p_pkg.sv
// Shared definitions for the 2-port data-memory arbiter and the memory wrapper.
package mem_arb_2p_pkg;

  // Default geometry of the 1024x8 data memory.
  localparam int unsigned MEM_AW = 10;
  localparam int unsigned MEM_DW = 8;

  // Controller state: initial clear sweep, then normal arbitration.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; prio names the port that wins a tie.
module rr_arb2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic prio_q;
  logic prio_d;

  // Grant a lone requester, or the prioritised one on a tie; hand priority to the other port after a grant.
  always_comb begin
    o_gnt0 = i_en & i_req0 & (~i_req1 | ~prio_q);
    o_gnt1 = i_en & i_req1 & (~i_req0 | prio_q);
    prio_d = prio_q;
    if (o_gnt0) begin
      prio_d = 1'b1;
    end else if (o_gnt1) begin
      prio_d = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_arb_2p.sv
// Controller for a single-port data memory shared by the CPU (port 0) and the
// debug loader (port 1): optional clear sweep, round-robin grants, read return.
module mem_arb_2p
  import mem_arb_2p_pkg::*;
#(
  parameter int unsigned    AW             = MEM_AW,
  parameter int unsigned    DW             = MEM_DW,
  parameter bit             CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0]  CLEAR_VAL      = '0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_p0_req,
  input  logic          i_p0_we,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [DW-1:0] i_p0_wdata,
  output logic          o_p0_gnt,
  output logic          o_p0_rvalid,
  output logic [DW-1:0] o_p0_rdata,
  input  logic          i_p1_req,
  input  logic          i_p1_we,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_wdata,
  output logic          o_p1_gnt,
  output logic          o_p1_rvalid,
  output logic [DW-1:0] o_p1_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic          arb_en;

  // Requests are only considered once the sweep is done and reset is released.
  assign arb_en = (state_q == ST_RUN) && !i_rst;

  rr_arb2 u_arb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (arb_en),
    .i_req0 (i_p0_req),
    .i_req1 (i_p1_req),
    .o_gnt0 (o_p0_gnt),
    .o_gnt1 (o_p1_gnt)
  );

  // Next state, memory port mux and read tagging; outputs are forced idle while reset is held.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rd_pend_d   = 1'b0;
    rd_owner_d  = rd_owner_q;
    o_mem_addr  = mem_addr_q;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    o_busy      = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        o_mem_addr  = clr_cnt_q;
        o_mem_we    = 1'b1;
        o_mem_wdata = CLEAR_VAL;
        o_busy      = 1'b1;
        clr_cnt_d   = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (o_p0_gnt) begin
          o_mem_addr  = i_p0_addr;
          o_mem_we    = i_p0_we;
          o_mem_wdata = i_p0_wdata;
          rd_pend_d   = ~i_p0_we;
          rd_owner_d  = 1'b0;
        end else if (o_p1_gnt) begin
          o_mem_addr  = i_p1_addr;
          o_mem_we    = i_p1_we;
          o_mem_wdata = i_p1_wdata;
          rd_pend_d   = ~i_p1_we;
          rd_owner_d  = 1'b1;
        end
      end
      default: ;
    endcase
    mem_addr_d = o_mem_addr;
    if (i_rst) begin
      o_mem_addr  = '0;
      o_mem_we    = 1'b0;
      o_mem_wdata = '0;
      o_busy      = CLEAR_ON_RESET;
    end
  end

  // Read data comes straight from the memory; only the owner's valid is raised.
  assign o_p0_rvalid = rd_pend_q & ~rd_owner_q & ~i_rst;
  assign o_p1_rvalid = rd_pend_q &  rd_owner_q & ~i_rst;
  assign o_p0_rdata  = i_mem_rdata;
  assign o_p1_rdata  = i_mem_rdata;

  // State, sweep counter, held address and read tag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q  <= '0;
      mem_addr_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      mem_addr_q <= mem_addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule
